rv32_retire_unit: RTL and testbench

//  Multi-lane successor to the single-lane writeback stage. It sits at the end of the pipeline and retires up to

---
 rtl/rv32_retire_pkg.sv | 31 +++
 rtl/rv32_retire_if.sv | 42 ++++
 rtl/rv32_trace_fifo.sv | 64 ++++++
 rtl/rv32_retire_unit.sv | 108 ++++++++++
 tb/tb_rv32_retire_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_retire_pkg.sv
// Shared types and helpers for the multi-lane retire unit.
//  trace_entry_t  : one trace FIFO record {trap, insn, pc}, TRACE_W bits
//  popcount_nret  : number of set bits in a lane mask
//  prefix_count   : number of set bits strictly below a lane index
// Lane masks are passed zero-extended to MAX_NRET so one function body
// serves every legal NRET.
package rv32_retire_pkg;
  localparam int TRACE_W  = 65;
  localparam int MAX_NRET = 4;

  typedef struct packed {
    logic        trap;
    logic [31:0] insn;
    logic [31:0] pc;
  } trace_entry_t;

  function automatic logic [2:0] popcount_nret(input logic [MAX_NRET-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_NRET; i++) c += 3'(m[i]);
    return c;
  endfunction

  function automatic logic [2:0] prefix_count(input logic [MAX_NRET-1:0] m, input int idx);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_NRET; i++)
      if (i < idx) c += 3'(m[i]);
    return c;
  endfunction
endpackage

// File: rtl/rv32_retire_if.sv
// Pipeline-side bundle of the retire unit: per-lane retire inputs, register
// file write port, instret, trace drain port and per-lane RVFI records.
//  master : pipeline / trace consumer side (drives *_in)
//  slave  : retire unit (drives *_out and rvfi_*)
interface rv32_retire_if #(parameter int NRET = 2);
  import rv32_retire_pkg::*;

  logic                       flush_in;
  logic [NRET-1:0]            valid_in, trap_in, rd_write_in;
  logic [NRET-1:0][31:0]      insn_in, pc_in, next_pc_in, rd_value_in;
  logic [NRET-1:0][4:0]       rd_in;

  logic                       stall_out;
  logic [NRET-1:0]            rf_write_out;
  logic [NRET-1:0][4:0]       rf_rd_out;
  logic [NRET-1:0][31:0]      rf_value_out;
  logic [63:0]                instret_out;

  logic                       trace_valid_out, trace_ready_in;
  trace_entry_t               trace_out;

  logic [NRET-1:0]            rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
  logic [NRET-1:0][63:0]      rvfi_order;
  logic [NRET-1:0][31:0]      rvfi_insn, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [NRET-1:0][1:0]       rvfi_mode;
  logic [NRET-1:0][4:0]       rvfi_rd_addr;

  modport master (
    output flush_in, valid_in, trap_in, insn_in, pc_in, next_pc_in, rd_in, rd_write_in,
           rd_value_in, trace_ready_in,
    input  stall_out, rf_write_out, rf_rd_out, rf_value_out, instret_out, trace_valid_out,
           trace_out, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata
  );
  modport slave (
    input  flush_in, valid_in, trap_in, insn_in, pc_in, next_pc_in, rd_in, rd_write_in,
           rd_value_in, trace_ready_in,
    output stall_out, rf_write_out, rf_rd_out, rf_value_out, instret_out, trace_valid_out,
           trace_out, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata
  );
endinterface

// File: rtl/rv32_trace_fifo.sv
// Multi-push / single-pop show-ahead FIFO for retired-instruction trace.
//  push_in/push_data_in : lanes to push this cycle; set lanes are packed in
//                         ascending lane order (holes are skipped)
//  pop_ready_in         : consumer accepts head (pop only when non-empty)
//  head_valid_out/head_out : current head entry
//  count_out            : registered occupancy, 0..TRACE_DEPTH
// The caller guarantees room for every push (it stalls on low free space).
module rv32_trace_fifo import rv32_retire_pkg::*; #(
  parameter int NRET        = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRET-1:0]                push_in,
  input  trace_entry_t [NRET-1:0]        push_data_in,
  input  logic                           pop_ready_in,
  output logic                           head_valid_out,
  output trace_entry_t                   head_out,
  output logic [$clog2(TRACE_DEPTH):0]   count_out
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem_q [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx [NRET];
  logic [2:0]    n_push;
  logic          pop;

  always_comb begin
    pop    = (count_q != '0) && pop_ready_in;
    n_push = popcount_nret(MAX_NRET'(push_in));
    // Each pushing lane lands after the lower pushing lanes; pointer
    // arithmetic wraps for free since the depth is a power of two.
    for (int i = 0; i < NRET; i++)
      wr_idx[i] = wr_ptr_q + AW'(prefix_count(MAX_NRET'(push_in), i));
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++)
      if (push_in[i]) mem_q[wr_idx[i]] <= push_data_in[i];
  end

  assign head_valid_out = (count_q != '0);
  assign head_out       = mem_q[rd_ptr_q];
  assign count_out      = count_q;
endmodule

// File: rtl/rv32_retire_unit.sv
// End-of-pipeline retire stage, NRET lanes per cycle (lane 0 oldest).
//  clk, reset : clock, synchronous active-high reset
//  bus        : rv32_retire_if slave -- lane inputs, combinational RF write
//               port, registered instret, trace FIFO drain port, and
//               registered RVFI records (1-cycle latency).
// stall_out looks only at registered FIFO occupancy so trace_ready_in has no
// combinational path to the hazard unit.
module rv32_retire_unit import rv32_retire_pkg::*; #(
  parameter int NRET        = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  rv32_retire_if.slave  bus
);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic [CW-1:0]             count;
  logic                      stall;
  logic [NRET-1:0]           retire, rf_write;
  trace_entry_t [NRET-1:0]   push_data;
  logic [63:0]               instret_q, instret_d, order_base_q, order_base_d;

  logic [NRET-1:0]           rvfi_valid_q, rvfi_valid_d, rvfi_trap_q, rvfi_trap_d;
  logic [NRET-1:0][63:0]     rvfi_order_q, rvfi_order_d;
  logic [NRET-1:0][31:0]     rvfi_insn_q, rvfi_insn_d, rvfi_wdata_q, rvfi_wdata_d;
  logic [NRET-1:0][31:0]     rvfi_pcr_q, rvfi_pcr_d, rvfi_pcw_q, rvfi_pcw_d;
  logic [NRET-1:0][4:0]      rvfi_rd_q, rvfi_rd_d;

  always_comb begin
    stall  = (CW'(TRACE_DEPTH) - count) < CW'(NRET);
    retire = (bus.flush_in || stall) ? '0 : (bus.valid_in | bus.trap_in);

    for (int i = 0; i < NRET; i++) begin
      push_data[i] = '{trap: bus.trap_in[i], insn: bus.insn_in[i], pc: bus.pc_in[i]};
      rf_write[i]  = retire[i] && bus.rd_write_in[i] && !bus.trap_in[i] && (bus.rd_in[i] != '0);
      // A younger lane writing the same register wins.
      for (int j = i + 1; j < NRET; j++)
        if (retire[j] && bus.rd_write_in[j] && !bus.trap_in[j] && (bus.rd_in[j] == bus.rd_in[i]))
          rf_write[i] = 1'b0;
    end

    instret_d    = instret_q + 64'(popcount_nret(MAX_NRET'(retire & ~bus.trap_in)));
    order_base_d = order_base_q + 64'(popcount_nret(MAX_NRET'(retire)));

    rvfi_valid_d = retire;
    rvfi_trap_d  = bus.trap_in;
    for (int i = 0; i < NRET; i++) begin
      rvfi_order_d[i] = order_base_q + 64'(prefix_count(MAX_NRET'(retire), i));
      rvfi_insn_d[i]  = bus.insn_in[i];
      rvfi_rd_d[i]    = bus.rd_write_in[i] ? bus.rd_in[i] : 5'd0;
      rvfi_wdata_d[i] = (bus.rd_write_in[i] && bus.rd_in[i] != '0) ? bus.rd_value_in[i] : 32'd0;
      rvfi_pcr_d[i]   = bus.pc_in[i];
      rvfi_pcw_d[i]   = bus.next_pc_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q    <= '0;
      order_base_q <= '0;
      rvfi_valid_q <= '0;
    end else begin
      instret_q    <= instret_d;
      order_base_q <= order_base_d;
      rvfi_valid_q <= rvfi_valid_d;
    end
  end

  // RVFI payload is only meaningful alongside rvfi_valid.
  always_ff @(posedge clk) begin
    rvfi_trap_q  <= rvfi_trap_d;
    rvfi_order_q <= rvfi_order_d;
    rvfi_insn_q  <= rvfi_insn_d;
    rvfi_rd_q    <= rvfi_rd_d;
    rvfi_wdata_q <= rvfi_wdata_d;
    rvfi_pcr_q   <= rvfi_pcr_d;
    rvfi_pcw_q   <= rvfi_pcw_d;
  end

  rv32_trace_fifo #(.NRET(NRET), .TRACE_DEPTH(TRACE_DEPTH)) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_in        (retire),
    .push_data_in   (push_data),
    .pop_ready_in   (bus.trace_ready_in),
    .head_valid_out (bus.trace_valid_out),
    .head_out       (bus.trace_out),
    .count_out      (count)
  );

  assign bus.stall_out     = stall;
  assign bus.rf_write_out  = rf_write;
  assign bus.rf_rd_out     = bus.rd_in;
  assign bus.rf_value_out  = bus.rd_value_in;
  assign bus.instret_out   = instret_q;
  assign bus.rvfi_valid    = rvfi_valid_q;
  assign bus.rvfi_order    = rvfi_order_q;
  assign bus.rvfi_insn     = rvfi_insn_q;
  assign bus.rvfi_trap     = rvfi_trap_q;
  assign bus.rvfi_halt     = '0;
  assign bus.rvfi_intr     = '0;
  assign bus.rvfi_mode     = {NRET{2'b11}};
  assign bus.rvfi_rd_addr  = rvfi_rd_q;
  assign bus.rvfi_rd_wdata = rvfi_wdata_q;
  assign bus.rvfi_pc_rdata = rvfi_pcr_q;
  assign bus.rvfi_pc_wdata = rvfi_pcw_q;
endmodule

// File: tb/tb_rv32_retire_unit.sv
// Bench for rv32_retire_unit: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_rv32_retire_unit;
  import rv32_retire_pkg::*;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_retire_if #(.NRET(NRET)) bus();
  rv32_retire_unit #(.NRET(NRET), .TRACE_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model state
  logic [63:0] m_instret, m_order;
  logic [64:0] m_q[$];
  logic        m_rv_valid[NRET], m_rv_trap[NRET];
  logic [63:0] m_rv_order[NRET];
  logic [31:0] m_rv_insn[NRET], m_rv_pc[NRET], m_rv_npc[NRET], m_rv_wdata[NRET];
  logic [4:0]  m_rv_rd[NRET];
  bit          model_ok = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_ret(input int i);
    bit full;
    full = (DEPTH - m_q.size()) < NRET;
    return !bus.flush_in && !full && (bus.valid_in[i] || bus.trap_in[i]);
  endfunction

  task automatic compare();
    logic [NRET-1:0] exp_wr, exp_rvv;
    int last[32];
    for (int r = 0; r < 32; r++) last[r] = -1;
    // Scan oldest to youngest; the final writer of each register survives.
    for (int i = 0; i < NRET; i++)
      if (m_ret(i) && bus.rd_write_in[i] && !bus.trap_in[i] && bus.rd_in[i] != 0)
        last[bus.rd_in[i]] = i;
    for (int i = 0; i < NRET; i++) begin
      exp_wr[i]  = m_ret(i) && bus.rd_write_in[i] && !bus.trap_in[i] && bus.rd_in[i] != 0
                   && last[bus.rd_in[i]] == i;
      exp_rvv[i] = m_rv_valid[i];
    end
    chk("stall_out", bus.stall_out, ((DEPTH - m_q.size()) < NRET) ? 1 : 0);
    chk("rf_write_out", bus.rf_write_out, exp_wr);
    chk("rf_rd_out", bus.rf_rd_out, bus.rd_in);
    chk("rf_value_out", bus.rf_value_out, bus.rd_value_in);
    chk("instret_out", bus.instret_out, m_instret);
    chk("trace_valid_out", bus.trace_valid_out, (m_q.size() != 0) ? 1 : 0);
    if (m_q.size() != 0) chk("trace_out", bus.trace_out, m_q[0]);
    chk("rvfi_valid", bus.rvfi_valid, exp_rvv);
    for (int i = 0; i < NRET; i++) begin
      if (m_rv_valid[i]) begin
        chk("rvfi_order", bus.rvfi_order[i], m_rv_order[i]);
        chk("rvfi_insn", bus.rvfi_insn[i], m_rv_insn[i]);
        chk("rvfi_trap", bus.rvfi_trap[i], m_rv_trap[i]);
        chk("rvfi_rd_addr", bus.rvfi_rd_addr[i], m_rv_rd[i]);
        chk("rvfi_rd_wdata", bus.rvfi_rd_wdata[i], m_rv_wdata[i]);
        chk("rvfi_pc_rdata", bus.rvfi_pc_rdata[i], m_rv_pc[i]);
        chk("rvfi_pc_wdata", bus.rvfi_pc_wdata[i], m_rv_npc[i]);
        chk("rvfi_him", {bus.rvfi_halt[i], bus.rvfi_intr[i], bus.rvfi_mode[i]}, 4'b0011);
      end
    end
  endtask

  task automatic model_update();
    logic ret[NRET];
    int k;
    if (reset) begin
      m_q.delete();
      m_instret = 0;
      m_order   = 0;
      for (int i = 0; i < NRET; i++) m_rv_valid[i] = 0;
      return;
    end
    for (int i = 0; i < NRET; i++) ret[i] = m_ret(i);
    if (m_q.size() != 0 && bus.trace_ready_in) void'(m_q.pop_front());
    k = 0;
    for (int i = 0; i < NRET; i++) begin
      m_rv_valid[i] = ret[i];
      m_rv_order[i] = m_order + 64'(k);
      m_rv_insn[i]  = bus.insn_in[i];
      m_rv_trap[i]  = bus.trap_in[i];
      m_rv_rd[i]    = bus.rd_write_in[i] ? bus.rd_in[i] : 5'd0;
      m_rv_wdata[i] = (bus.rd_write_in[i] && bus.rd_in[i] != 0) ? bus.rd_value_in[i] : 32'd0;
      m_rv_pc[i]    = bus.pc_in[i];
      m_rv_npc[i]   = bus.next_pc_in[i];
      if (ret[i]) begin
        k++;
        m_q.push_back({bus.trap_in[i], bus.insn_in[i], bus.pc_in[i]});
        if (!bus.trap_in[i]) m_instret++;
      end
    end
    m_order += 64'(k);
  endtask

  task automatic step();
    @(negedge clk);
    if (model_ok) compare();
    model_update();
    model_ok = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_in    = 0;
    bus.valid_in    = '0;
    bus.trap_in     = '0;
    bus.rd_write_in = '0;
    for (int i = 0; i < NRET; i++) begin
      bus.insn_in[i]     = 32'h0000_0013 + 32'(i);
      bus.pc_in[i]       = 32'h200 + 32'(4 * i);
      bus.next_pc_in[i]  = 32'h204 + 32'(4 * i);
      bus.rd_in[i]       = '0;
      bus.rd_value_in[i] = '0;
    end
  endtask

  task automatic lanes(input logic [31:0] pc0);
    for (int i = 0; i < NRET; i++) begin
      bus.pc_in[i]      = pc0 + 32'(4 * i);
      bus.next_pc_in[i] = pc0 + 32'(4 * i + 4);
      bus.insn_in[i]    = pc0 ^ 32'h00A0_0033 ^ 32'(i);
    end
  endtask

  initial begin
    idle();
    bus.trace_ready_in = 1;
    reset = 1;
    step();
    reset = 0;
    chk("reset trace_valid", bus.trace_valid_out, 0);
    chk("reset instret", bus.instret_out, 0);
    chk("reset stall", bus.stall_out, 0);
    chk("reset rvfi_valid", bus.rvfi_valid, 0);

    // Same-rd conflict: youngest lane wins
    lanes(32'h100);
    bus.valid_in = 2'b11; bus.rd_write_in = 2'b11;
    bus.rd_in[0] = 5; bus.rd_in[1] = 5;
    bus.rd_value_in[0] = 32'hA; bus.rd_value_in[1] = 32'hB;
    #1;
    chk("t1 rf_write", bus.rf_write_out, 2'b10);
    chk("t1 rf_value", bus.rf_value_out[1], 32'hB);
    step();
    chk("t1 instret", bus.instret_out, 2);
    chk("t1 order0", bus.rvfi_order[0], 0);
    chk("t1 order1", bus.rvfi_order[1], 1);

    // Hole in lane 0
    idle(); lanes(32'h108);
    bus.valid_in = 2'b10; bus.rd_write_in = 2'b10;
    bus.rd_in[1] = 3; bus.rd_value_in[1] = 32'h7;
    #1;
    chk("t2 rf_write", bus.rf_write_out, 2'b10);
    step();
    chk("t2 rvfi_valid", bus.rvfi_valid, 2'b10);
    chk("t2 order1", bus.rvfi_order[1], 2);
    chk("t2 instret", bus.instret_out, 3);

    // Trapping lane with rd write
    idle(); lanes(32'h110);
    bus.valid_in = 2'b01; bus.trap_in = 2'b01; bus.rd_write_in = 2'b01;
    bus.rd_in[0] = 4; bus.rd_value_in[0] = 32'h7;
    #1;
    chk("t3 rf_write", bus.rf_write_out, 0);
    step();
    chk("t3 instret", bus.instret_out, 3);
    chk("t3 rvfi_trap", bus.rvfi_trap[0], 1);
    chk("t3 rvfi_wdata", bus.rvfi_rd_wdata[0], 32'h7);
    chk("t3 order0", bus.rvfi_order[0], 3);

    // Flush squashes everything
    idle(); lanes(32'h118);
    bus.flush_in = 1; bus.valid_in = 2'b11; bus.rd_write_in = 2'b11;
    bus.rd_in[0] = 1; bus.rd_in[1] = 2;
    #1;
    chk("t5 rf_write", bus.rf_write_out, 0);
    step();
    chk("t5 rvfi_valid", bus.rvfi_valid, 0);
    chk("t5 instret", bus.instret_out, 3);
    idle(); lanes(32'h120);
    bus.valid_in = 2'b01;
    step();
    chk("t5 order after flush", bus.rvfi_order[0], 4);

    idle();
    for (int c = 0; c < 8; c++) step();
    chk("drained", bus.trace_valid_out, 0);

    // Fill FIFO with consumer blocked, then drain
    bus.trace_ready_in = 0;
    for (int c = 0; c < 4; c++) begin
      lanes(32'h1000 + 32'(8 * c));
      bus.valid_in = 2'b11;
      step();
    end
    chk("t4 stall full", bus.stall_out, 1);
    chk("t4 head pc", bus.trace_out.pc, 32'h1000);
    idle();
    bus.trace_ready_in = 1;
    step();
    chk("t4 stall at 7", bus.stall_out, 1);
    step();
    chk("t4 stall at 6", bus.stall_out, 0);
    for (int c = 0; c < 6; c++) step();
    chk("t4 empty", bus.trace_valid_out, 0);

    // Reset mid-operation with five buffered entries
    bus.trace_ready_in = 0;
    lanes(32'h2000); bus.valid_in = 2'b11; step();
    lanes(32'h2008); step();
    lanes(32'h2010); bus.valid_in = 2'b01; step();
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("t6 trace_valid", bus.trace_valid_out, 0);
    chk("t6 instret", bus.instret_out, 0);
    chk("t6 stall", bus.stall_out, 0);
    bus.trace_ready_in = 1;
    lanes(32'h3000); bus.valid_in = 2'b11;
    step();
    chk("t6 order0", bus.rvfi_order[0], 0);
    chk("t6 order1", bus.rvfi_order[1], 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.flush_in       = ($urandom_range(0, 15) == 0);
      bus.valid_in       = NRET'($urandom);
      bus.rd_write_in    = NRET'($urandom);
      bus.trace_ready_in = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NRET; i++) begin
        bus.trap_in[i]     = ($urandom_range(0, 7) == 0);
        bus.rd_in[i]       = 5'($urandom_range(0, 3));
        bus.rd_value_in[i] = $urandom;
        bus.insn_in[i]     = $urandom;
        bus.pc_in[i]       = $urandom;
        bus.next_pc_in[i]  = $urandom;
      end
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
